// File: rtl/fpu_wb_pipe_if.sv
`default_nettype none
// ============================================================================
// fpu_wb_pipe_if : issue, unit-result, lookup and write-back bundle of fpu_wb_pipe
// Revision: 1.0
// ============================================================================
interface fpu_wb_pipe_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 5
);
  localparam int IW = $clog2(DEPTH + 1);

  logic             issue_valid;
  logic [1:0]       issue_cls;
  logic [AW-1:0]    issue_rd;
  logic [WIDTH-1:0] move_data;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] adsb_data;
  logic [WIDTH-1:0] mult_data;
  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             rs1_rdy;
  logic             rs2_rdy;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [IW-1:0]    inflight;

  modport master (
    output issue_valid, issue_cls, issue_rd, move_data,
    output load_data, adsb_data, mult_data, rs1_addr, rs2_addr,
    input  rs1_hit, rs2_hit, rs1_rdy, rs2_rdy, rs1_data, rs2_data,
    input  wb_en, wb_addr, wb_data, inflight
  );

  modport slave (
    input  issue_valid, issue_cls, issue_rd, move_data,
    input  load_data, adsb_data, mult_data, rs1_addr, rs2_addr,
    output rs1_hit, rs2_hit, rs1_rdy, rs2_rdy, rs1_data, rs2_data,
    output wb_en, wb_addr, wb_data, inflight
  );
endinterface
`default_nettype wire

// File: rtl/fpu_wb_pipe.sv
`default_nettype none
// ============================================================================
// fpu_wb_pipe : latency-parametrised FP result tracking, capture and write-back
// Revision: 1.0
// ============================================================================
module fpu_wb_pipe #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 5,
  parameter int LAT_LOAD = 2,
  parameter int LAT_ADSB = 3,
  parameter int LAT_MULT = 5
) (
  input  logic         clk,
  input  logic         rst,
  fpu_wb_pipe_if.slave bus
);
  localparam int         IW       = $clog2(DEPTH + 1);
  localparam logic [1:0] CLS_MOVE = 2'd0;
  localparam logic [1:0] CLS_LOAD = 2'd1;
  localparam logic [1:0] CLS_ADSB = 2'd2;
  localparam logic [1:0] CLS_MULT = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [1:0]       cls;
    logic [AW-1:0]    rd;
    logic             rdy;
    logic [WIDTH-1:0] data;
  } slot_t;

  typedef struct packed {
    logic             hit;
    logic             rdy;
    logic [WIDTH-1:0] data;
  } look_t;

  slot_t         slot_q [1:DEPTH];
  slot_t         slot_d [1:DEPTH];
  logic [IW-1:0] inflight_q;
  logic [IW-1:0] inflight_d;
  look_t         look1;
  look_t         look2;

  function automatic logic captures(input logic [1:0] cls, input int s);
    case (cls)
      CLS_LOAD: return s == LAT_LOAD;
      CLS_ADSB: return s == LAT_ADSB;
      CLS_MULT: return s == LAT_MULT;
      default:  return 1'b0;
    endcase
  endfunction

  // Scan oldest to youngest so the lowest-index match is the one left standing.
  function automatic look_t lookup(input logic [AW-1:0] addr);
    look_t r;
    r = '0;
    for (int s = DEPTH; s >= 1; s--) begin
      if (slot_q[s].valid && slot_q[s].rd == addr) begin
        r.hit  = 1'b1;
        r.rdy  = slot_q[s].rdy;
        r.data = slot_q[s].data;
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int s = 1; s <= DEPTH; s++) begin
      slot_d[s] = '0;
    end
    if (bus.issue_valid) begin
      slot_d[1].valid = 1'b1;
      slot_d[1].cls   = bus.issue_cls;
      slot_d[1].rd    = bus.issue_rd;
      if (bus.issue_cls == CLS_MOVE) begin
        slot_d[1].data = bus.move_data;
        slot_d[1].rdy  = 1'b1;
      end
    end
    for (int s = 2; s <= DEPTH; s++) begin
      slot_d[s] = slot_q[s-1];
      if (slot_q[s-1].valid && captures(slot_q[s-1].cls, s)) begin
        slot_d[s].rdy = 1'b1;
        case (slot_q[s-1].cls)
          CLS_LOAD: slot_d[s].data = bus.load_data;
          CLS_ADSB: slot_d[s].data = bus.adsb_data;
          default:  slot_d[s].data = bus.mult_data;
        endcase
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q + IW'(bus.issue_valid) - IW'(slot_q[DEPTH].valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 1; s <= DEPTH; s++) begin
        slot_q[s] <= '0;
      end
      inflight_q <= '0;
    end else begin
      for (int s = 1; s <= DEPTH; s++) begin
        slot_q[s] <= slot_d[s];
      end
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    look1 = lookup(bus.rs1_addr);
    look2 = lookup(bus.rs2_addr);
  end

  assign bus.rs1_hit  = look1.hit;
  assign bus.rs1_rdy  = look1.rdy;
  assign bus.rs1_data = look1.data;
  assign bus.rs2_hit  = look2.hit;
  assign bus.rs2_rdy  = look2.rdy;
  assign bus.rs2_data = look2.data;
  assign bus.wb_en    = slot_q[DEPTH].valid;
  assign bus.wb_addr  = slot_q[DEPTH].rd;
  assign bus.wb_data  = slot_q[DEPTH].data;
  assign bus.inflight = inflight_q;
endmodule
`default_nettype wire
